// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Central hazard controller for the 5-stage MIPS pipeline.
//                Generates the F/D+PC stall and the D/E bubble, the
//                forwarding-mux selects for the D, E and M stages, and tracks
//                the multi-cycle mult/div unit (XALU) with a busy counter so
//                HI/LO consumers wait for the result.
//                Optional macro HAZARD_PERF_EN adds the stall_cycles and
//                md_stall_cycles performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic [4:0]  rs_E,
    input  logic [4:0]  rt_E,
    input  logic [4:0]  dst_E,
    input  logic [1:0]  tnew_E,
    input  logic [4:0]  dst_M,
    input  logic [1:0]  tnew_M,
    input  logic [4:0]  rt_M,
    input  logic [4:0]  dst_W,
    input  logic        md_start_E,
    input  logic        md_is_div_E,
    input  logic        md_use_D,
    output logic        stall,
    output logic        clr_DE,
    output logic [1:0]  fwd_rs_D,
    output logic [1:0]  fwd_rt_D,
    output logic [1:0]  fwd_rs_E,
    output logic [1:0]  fwd_rt_E,
    output logic        fwd_rt_M,
    output logic        md_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] md_stall_cycles
`endif
);

    localparam logic [3:0] c_MULT_LAT = 4'(MULT_LAT);
    localparam logic [3:0] c_DIV_LAT  = 4'(DIV_LAT);
    localparam logic [1:0] c_TUSE_NONE = 2'd3;

    // Forwarding select codes
    localparam logic [1:0] c_SEL_NONE = 2'd0;
    localparam logic [1:0] c_SEL_E    = 2'd1;
    localparam logic [1:0] c_SEL_M    = 2'd2;
    localparam logic [1:0] c_SEL_W    = 2'd3;

    logic [3:0] r_md_cnt;
    logic       w_stall_rs;
    logic       w_stall_rt;
    logic       w_md_stall;
    logic       w_stall;
    logic       w_md_busy;

    // A register operand stalls when a producer in E or M writes it but will
    // not have the value ready by the time D's instruction consumes it.
    function automatic logic f_reg_stall(input logic [4:0] src, input logic [1:0] tuse);
        logic hit_e;
        logic hit_m;
        hit_e = (src == dst_E) && (tnew_E > tuse);
        hit_m = (src == dst_M) && (tnew_M > tuse);
        return (src != 5'd0) && (tuse != c_TUSE_NONE) && (hit_e || hit_m);
    endfunction

    // Nearest ready producer wins; $0 is hard-wired and never forwarded.
    function automatic logic [1:0] f_fwd_d(input logic [4:0] src);
        logic [1:0] sel;
        sel = c_SEL_NONE;
        if (src != 5'd0) begin
            if ((src == dst_E) && (tnew_E == 2'd0)) begin
                sel = c_SEL_E;
            end else if ((src == dst_M) && (tnew_M == 2'd0)) begin
                sel = c_SEL_M;
            end else if (src == dst_W) begin
                sel = c_SEL_W;
            end
        end
        return sel;
    endfunction

    function automatic logic [1:0] f_fwd_e(input logic [4:0] src);
        logic [1:0] sel;
        sel = c_SEL_NONE;
        if (src != 5'd0) begin
            if ((src == dst_M) && (tnew_M == 2'd0)) begin
                sel = c_SEL_M;
            end else if (src == dst_W) begin
                sel = c_SEL_W;
            end
        end
        return sel;
    endfunction

    // XALU busy counter: a start (re)loads the latency, otherwise count down.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt <= 4'd0;
        end else if (md_start_E) begin
            r_md_cnt <= md_is_div_E ? c_DIV_LAT : c_MULT_LAT;
        end else if (r_md_cnt != 4'd0) begin
            r_md_cnt <= r_md_cnt - 4'd1;
        end
    end

    // Stall / bubble generation; everything is forced quiet during reset.
    always_comb begin
        w_stall_rs = f_reg_stall(rs_D, tuse_rs_D);
        w_stall_rt = f_reg_stall(rt_D, tuse_rt_D);
        w_md_busy  = !reset && (md_start_E || (r_md_cnt != 4'd0));
        w_md_stall = md_use_D && w_md_busy;
        w_stall    = !reset && (w_stall_rs || w_stall_rt || w_md_stall);
        stall      = w_stall;
        clr_DE     = w_stall;
        md_busy    = w_md_busy;
    end

    // Forwarding selects for the D, E and M stage operand muxes.
    always_comb begin
        fwd_rs_D = f_fwd_d(rs_D);
        fwd_rt_D = f_fwd_d(rt_D);
        fwd_rs_E = f_fwd_e(rs_E);
        fwd_rt_E = f_fwd_e(rt_E);
        fwd_rt_M = (rt_M != 5'd0) && (rt_M == dst_W);
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_md_stall_cycles;
    logic        w_md_only;

    // A stall counts as XALU-induced only when no register hazard is present.
    always_comb begin
        w_md_only = w_stall && w_md_stall && !w_stall_rs && !w_stall_rt;
    end

    // Free-running stall counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles    <= 32'd0;
            r_md_stall_cycles <= 32'd0;
        end else begin
            if (w_stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_md_only) begin
                r_md_stall_cycles <= r_md_stall_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles    = r_stall_cycles;
    assign md_stall_cycles = r_md_stall_cycles;
`endif

endmodule
`default_nettype wire
